// File: rtl/snn_pkg.sv
// Shared definitions for the SNN timestep sequencer.
//   - seq_state_t : sequencer FSM states
//   - cls_w()     : index width for N classes / layers (never below 1)
//   - sat_add_w() : width of an unsaturated counter increment (carry bit
//                   flags saturation)
//   - DEF_*       : default parameter values
package snn_pkg;

    localparam int DEF_N_IN        = 30;
    localparam int DEF_N_OUT       = 5;
    localparam int DEF_N_LAYERS    = 3;
    localparam int DEF_STEP_W      = 8;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_LAYER,
        ST_ARGMAX,
        ST_RESULT
    } seq_state_t;

    function automatic int cls_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sat_add_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/snn_timestep_sequencer_if.sv
// Bundle of all non-clock signals of the timestep sequencer.
//   master : run control, input frame source, layer engines (drive inputs)
//   slave  : the sequencer itself
// Signals: run_start, abort, n_steps, in_valid/in_ready/in_bits, frame_bits,
//          layer_start/layer_done, out_spikes, busy, done, class_id,
//          class_count, err.
interface snn_timestep_sequencer_if
    import snn_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int N_LAYERS = DEF_N_LAYERS,
    parameter int STEP_W   = DEF_STEP_W,
    parameter int CNT_W    = DEF_CNT_W
);
    logic                      run_start;
    logic                      abort;
    logic [STEP_W-1:0]         n_steps;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN-1:0]           in_bits;
    logic [N_IN-1:0]           frame_bits;
    logic [N_LAYERS-1:0]       layer_start;
    logic [N_LAYERS-1:0]       layer_done;
    logic [N_OUT-1:0]          out_spikes;
    logic                      busy;
    logic                      done;
    logic [cls_w(N_OUT)-1:0]   class_id;
    logic [CNT_W-1:0]          class_count;
    logic                      err;

    modport master (
        output run_start, abort, n_steps, in_valid, in_bits, layer_done, out_spikes,
        input  in_ready, frame_bits, layer_start, busy, done, class_id, class_count, err
    );

    modport slave (
        input  run_start, abort, n_steps, in_valid, in_bits, layer_done, out_spikes,
        output in_ready, frame_bits, layer_start, busy, done, class_id, class_count, err
    );
endinterface

// File: rtl/snn_class_counter.sv
// N_OUT saturating per-class spike counters plus a sequential argmax scanner.
//   clr       : clear counters, scan index and best-so-far
//   add_en    : add spikes[i] to counter i (saturating at 2^CNT_W-1)
//   scan_en   : examine one class per cycle, lowest index first
//   scan_last : the class being examined this cycle is the last one
//   best_idx/best_cnt : current argmax (ties keep the lower index)
module snn_class_counter
    import snn_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    add_en,
    input  logic [N_OUT-1:0]        spikes,
    input  logic                    scan_en,
    output logic                    scan_last,
    output logic [cls_w(N_OUT)-1:0] best_idx,
    output logic [CNT_W-1:0]        best_cnt
);
    localparam int CLS_W = cls_w(N_OUT);
    localparam int SUM_W = sat_add_w(CNT_W);

    logic [N_OUT*CNT_W-1:0] cnt_flat;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [SUM_W-1:0] sum;

            // Carry out of the widened sum means the counter is already at max.
            assign sum = SUM_W'(cnt_reg) + SUM_W'(spikes[gi]);

            always_ff @(posedge clk) begin
                if (rst || clr)
                    cnt_reg <= '0;
                else if (add_en)
                    cnt_reg <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    logic [CLS_W-1:0] scan_idx_reg;
    logic [CLS_W-1:0] best_idx_reg;
    logic [CNT_W-1:0] best_cnt_reg;
    logic [CNT_W-1:0] cur_cnt;

    assign cur_cnt   = cnt_flat[scan_idx_reg*CNT_W +: CNT_W];
    assign scan_last = (scan_idx_reg == CLS_W'(N_OUT-1));

    // Best starts at (0, 0); strict '>' keeps the first class among equals.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            scan_idx_reg <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
        end else if (scan_en) begin
            if (cur_cnt > best_cnt_reg) begin
                best_cnt_reg <= cur_cnt;
                best_idx_reg <= scan_idx_reg;
            end
            scan_idx_reg <= scan_idx_reg + 1'b1;
        end
    end

    assign best_idx = best_idx_reg;
    assign best_cnt = best_cnt_reg;
endmodule

// File: rtl/snn_timestep_sequencer.sv
// Multi-timestep sequencer for a chain of N_LAYERS LIF layer engines.
// Accepts one input frame per timestep, starts each layer in turn, counts
// last-layer spikes per class over n_steps timesteps, then reports argmax.
// Ports: clk, rst (synchronous, active high), bus (slave modport of
//        snn_timestep_sequencer_if carrying all control/data signals).
// Option: define SNN_SEQ_TIMEOUT_EN to add a per-layer watchdog that ends a
//         run with err=1 after TIMEOUT_CYC cycles without the expected done.
module snn_timestep_sequencer
    import snn_pkg::*;
#(
    parameter int N_IN        = DEF_N_IN,
    parameter int N_OUT       = DEF_N_OUT,
    parameter int N_LAYERS    = DEF_N_LAYERS,
    parameter int STEP_W      = DEF_STEP_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic                     clk,
    input logic                     rst,
    snn_timestep_sequencer_if.slave bus
);
    localparam int CLS_W = cls_w(N_OUT);
    localparam int KW    = cls_w(N_LAYERS);

    seq_state_t        state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [STEP_W-1:0] last_step_reg, last_step_next;
    logic              first_reg, first_next;
    logic [N_IN-1:0]   frame_reg, frame_next;
    logic [CLS_W-1:0]  class_id_reg, class_id_next;
    logic [CNT_W-1:0]  class_count_reg, class_count_next;
    logic              done_reg, done_next;

    logic              clr, add_en, scan_en, scan_last;
    logic              hit, last_layer, last_step;
    logic [CLS_W-1:0]  best_idx;
    logic [CNT_W-1:0]  best_cnt;

`ifdef SNN_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            err_reg, err_next;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    // Only the current layer's done is honoured; all other pulses are ignored.
    assign hit        = bus.layer_done[k_reg];
    assign last_layer = (k_reg == KW'(N_LAYERS-1));
    assign last_step  = (step_reg == last_step_reg);

    snn_class_counter #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) u_class_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .add_en    (add_en),
        .spikes    (bus.out_spikes),
        .scan_en   (scan_en),
        .scan_last (scan_last),
        .best_idx  (best_idx),
        .best_cnt  (best_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            k_reg           <= '0;
            step_reg        <= '0;
            last_step_reg   <= '0;
            first_reg       <= 1'b0;
            frame_reg       <= '0;
            class_id_reg    <= '0;
            class_count_reg <= '0;
            done_reg        <= 1'b0;
`ifdef SNN_SEQ_TIMEOUT_EN
            wd_reg          <= '0;
            err_reg         <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            step_reg        <= step_next;
            last_step_reg   <= last_step_next;
            first_reg       <= first_next;
            frame_reg       <= frame_next;
            class_id_reg    <= class_id_next;
            class_count_reg <= class_count_next;
            done_reg        <= done_next;
`ifdef SNN_SEQ_TIMEOUT_EN
            wd_reg          <= wd_next;
            err_reg         <= err_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        k_next           = k_reg;
        step_next        = step_reg;
        last_step_next   = last_step_reg;
        first_next       = 1'b0;
        frame_next       = frame_reg;
        class_id_next    = class_id_reg;
        class_count_next = class_count_reg;
        done_next        = 1'b0;
        clr              = 1'b0;
        add_en           = 1'b0;
        scan_en          = 1'b0;
`ifdef SNN_SEQ_TIMEOUT_EN
        wd_next          = '0;
        err_next         = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.run_start) begin
                    clr              = 1'b1;
                    k_next           = '0;
                    step_next        = '0;
                    // n_steps = 0 runs a single timestep, same as n_steps = 1.
                    last_step_next   = (bus.n_steps == '0) ? '0 : bus.n_steps - 1'b1;
                    class_id_next    = '0;
                    class_count_next = '0;
`ifdef SNN_SEQ_TIMEOUT_EN
                    err_next         = 1'b0;
`endif
                    state_next       = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (bus.in_valid) begin
                    frame_next = bus.in_bits;
                    k_next     = '0;
                    first_next = 1'b1;
                    state_next = ST_LAYER;
                end
            end
            ST_LAYER: begin
                if (hit) begin
                    if (!last_layer) begin
                        k_next     = k_reg + 1'b1;
                        first_next = 1'b1;
                    end else begin
                        add_en = 1'b1;
                        if (last_step) begin
                            state_next = ST_ARGMAX;
                        end else begin
                            step_next  = step_reg + 1'b1;
                            state_next = ST_WAIT_IN;
                        end
                    end
                end
`ifdef SNN_SEQ_TIMEOUT_EN
                else if (wd_reg == WD_W'(TIMEOUT_CYC-1)) begin
                    err_next         = 1'b1;
                    done_next        = 1'b1;
                    class_id_next    = '0;
                    class_count_next = '0;
                    state_next       = ST_IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
`endif
            end
            ST_ARGMAX: begin
                scan_en = 1'b1;
                if (scan_last)
                    state_next = ST_RESULT;
            end
            ST_RESULT: begin
                class_id_next    = best_idx;
                class_count_next = best_cnt;
                done_next        = 1'b1;
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything else on the same edge, with no done pulse
        // and no update of the reported results.
        if (bus.abort && (state_reg != ST_IDLE)) begin
            state_next       = ST_IDLE;
            first_next       = 1'b0;
            done_next        = 1'b0;
            add_en           = 1'b0;
            scan_en          = 1'b0;
            class_id_next    = class_id_reg;
            class_count_next = class_count_reg;
`ifdef SNN_SEQ_TIMEOUT_EN
            err_next         = err_reg;
`endif
        end
    end

    assign bus.in_ready    = (state_reg == ST_WAIT_IN);
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.frame_bits  = frame_reg;
    assign bus.layer_start = (state_reg == ST_LAYER && first_reg) ? (N_LAYERS'(1) << k_reg) : '0;
    assign bus.done        = done_reg;
    assign bus.class_id    = class_id_reg;
    assign bus.class_count = class_count_reg;
`ifdef SNN_SEQ_TIMEOUT_EN
    assign bus.err         = err_reg;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: doc/snn_timestep_sequencer.md
# snn_timestep_sequencer

Parametrised top-level sequencer for a feed-forward LIF spiking network of N_LAYERS layer engines. It runs a complete multi-timestep inference: it accepts one input spike frame per timestep over a valid/ready handshake, then chains start/done through every layer in order. It accumulates saturating per-class output spike counts over n_steps timesteps and reports the argmax class. It sits above the per-layer engines and replaces the fixed 3-layer, single-timestep controller.

## Interface
- N_IN, 30, input spike frame width (layer 0 fan-in)
- N_OUT, 5, class count (last layer fan-out)
- N_LAYERS, 3, number of chained layer engines, ≥1
- STEP_W, 8, width of n_steps
- CNT_W, 8, per-class spike counter width
- TIMEOUT_CYC, 1024, per-layer watchdog limit in cycles (used only with the timeout option)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- run_start  in  1  pulse; accepted only when busy=0
- abort  in  1  synchronous; forces IDLE the next edge; no done pulse
- n_steps  in  STEP_W  timesteps per run; sampled on run accept; 0 is treated as 1
- in_valid  in  1  input frame valid
- in_ready  out  1  high only in WAIT_IN
- in_bits  in  N_IN  input spike frame
- frame_bits  out  N_IN  registered frame driven to layer 0; held until the next accepted frame
- layer_start  out  N_LAYERS  one-hot, 1-cycle start pulses
- layer_done  in  N_LAYERS  1-cycle done pulses from the engines
- out_spikes  in  N_OUT  last-layer spikes; valid while layer_done[N_LAYERS-1]=1
- busy  out  1  high from run accept until done/abort
- done  out  1  1-cycle pulse when results are valid
- class_id  out  $clog2(N_OUT)  argmax class
- class_count  out  CNT_W  winning count
- err  out  1  timeout flag

## Operation
- States: IDLE, WAIT_IN, LAYER, ARGMAX, RESULT.
- IDLE:
  - On run_start: clear all counters, step index, layer index and err; latch n_steps; go to WAIT_IN.
- WAIT_IN:
  - in_ready=1.
  - On in_valid&in_ready: register in_bits into frame_bits, set layer index k=0, go to LAYER.
- LAYER:
  - layer_start[k] pulses on the first cycle of LAYER for each k.
  - Only layer_done[k] is honoured. Done pulses from other layers, and repeated pulses, are ignored.
  - On layer_done[k] with k<N_LAYERS-1: k←k+1, re-enter LAYER.
  - On layer_done[N_LAYERS-1]: add out_spikes[i] to cnt[i] for every i, saturating at 2^CNT_W−1.
  - Then, if the step index equals n_steps−1, go to ARGMAX; otherwise increment the step index and go to WAIT_IN.
- ARGMAX:
  - Sequential scan, one class per cycle, N_OUT cycles.
  - A strictly greater count replaces the current best, so ties resolve to the lowest index.
  - Then go to RESULT.
- RESULT:
  - Register class_id and class_count, pulse done, go to IDLE.
  - Both outputs hold until the next run accept.
- Boundaries:
  - run_start while busy: ignored.
  - abort and layer_done on the same edge: abort wins.
  - abort in IDLE: no effect.
  - rst mid-run: immediate IDLE, all state cleared.

## Timing
- Reset values:
  - in_ready, busy, done, err: 0.
  - layer_start: all 0.
  - frame_bits, class_id, class_count: 0.
- Cycle-level sequence:
  - run_start sampled at edge t → busy=1 and in_ready=1 from t+1.
  - Frame handshake at edge f → layer_start[0]=1 during cycle f+1.
  - layer_done[k] at edge d → layer_start[k+1]=1 during cycle d+1.
  - Last layer_done at edge e (final step) → done=1 during cycle e+N_OUT+2; busy falls in the same cycle.
- Per-timestep controller overhead is 1 cycle per layer hop plus 1 cycle for the frame accept.

## Configuration
- SNN_SEQ_TIMEOUT_EN defined:
  - A watchdog counter restarts at each layer_start.
  - If layer_done[k] is not seen within TIMEOUT_CYC cycles, set err=1 (sticky until the next run accept), pulse done, and go to IDLE with class_id=0 and class_count=0.
- Not defined:
  - No watchdog; LAYER waits indefinitely.
  - err is tied to 0.

## Structure
- Shared package snn_pkg holds:
  - the state enum;
  - the saturating-add width helper;
  - the class-index width function;
  - default parameter constants.
- One natural sub-module: snn_class_counter, holding N_OUT saturating counters plus the sequential argmax scanner.

## Test plan
- Basic run: N_LAYERS=3, n_steps=4, engines answer done 5 cycles after start, out_spikes=5'b00100 every step → done with class_id=2, class_count=4, err=0; exactly 12 layer_start pulses, in order 0,1,2.
- Tie: step spikes 5'b01010 for 3 steps → class_id=1, class_count=3.
- Saturation: CNT_W=2, n_steps=6, class 4 spikes every step → class_count=3, class_id=4.
- Protocol: in_valid held low for 10 cycles in WAIT_IN → no layer_start; run_start while busy → ignored; spurious layer_done[2] during layer 0 → ignored.
- n_steps=0 → exactly one timestep executed. abort mid-LAYER → busy=0 next cycle, no done; a following run completes normally.
- With SNN_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, layer 1 never answers → err=1 and done pulse; without the macro, busy stays high.
